mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 16, data word width.
REQ-002 Parameter ADDR_W, default 16, address width presented by the controller.
REQ-003 Parameter IDX_W, default 8, index width of the storage array (2**IDX_W words).
REQ-004 Parameter LATENCY, default 2, access latency in cycles; legal range 1..15.
REQ-005 clk  input  1  single system clock, rising-edge active.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 MemRead  input  1  read request from the controller, held until ready.
REQ-008 MemWrite  input  1  write request from the controller, held until ready.
REQ-009 addr  input  ADDR_W  word address from MAR.
REQ-010 wdata  input  DATA_W  write data from MDR.
REQ-011 rdata  output  DATA_W  registered read data, for MDR capture (MDRMemRead).
REQ-012 ready  output  1  one-cycle completion pulse to the controller.
REQ-013 err  output  1  one-cycle pulse with ready when a request was illegal.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, DONE, HOLD.
REQ-016 In IDLE, a rising edge with MemRead or MemWrite high SHALL latch addr[IDX_W-1:0], wdata and the operation, load the counter with LATENCY-1, and move to BUSY.
REQ-017 Upper address bits addr[ADDR_W-1:IDX_W] SHALL be ignored (index wraps modulo 2**IDX_W).
REQ-018 In BUSY the counter SHALL decrement each edge; on the edge where it is 0, the state SHALL move to DONE.
REQ-019 ready SHALL be high for exactly the one cycle spent in DONE, i.e. it rises on the LATENCY-th rising edge after the sampling edge.
REQ-020 A read SHALL update rdata on the edge entering DONE; rdata SHALL hold until the next read completes.
REQ-021 A write SHALL commit to the array on the edge entering DONE; rdata SHALL be unchanged by writes.
REQ-022 MemRead and MemWrite both high at the sampling edge SHALL be illegal: no array access, rdata unchanged, err pulsed together with ready.
REQ-023 From DONE, the state SHALL go to HOLD; HOLD SHALL return to IDLE only on an edge where MemRead and MemWrite are both low, so a held request is never serviced twice.
REQ-024 Request or input changes during BUSY, DONE or HOLD SHALL be ignored.
REQ-025 A read of an address written earlier SHALL return the last written value.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, ready 0, err 0, busy 0, rdata 0.
REQ-027 Reset during BUSY SHALL abort the access, and a pending write SHALL NOT be committed.
REQ-028 Array contents SHALL NOT be reset and are undefined until written.
REQ-029 The first request SHALL be sampled no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package mem_pkg SHALL hold DATA_W/ADDR_W/IDX_W defaults and the state enumeration.
REQ-031 Storage SHALL be a sub-module mem_array: a single-port synchronous RAM with write enable, index, write data and registered read data.
REQ-032 The FSM, counter and handshake SHALL live in mem_responder; no combinational path SHALL exist from MemRead/MemWrite to ready.

Verification
REQ-033 LATENCY=2: MemWrite=1, addr=0x0012, wdata=0xBEEF at edge E0 -> ready=1 only in the cycle after E2, err=0; then MemRead at addr 0x0012 -> rdata=0xBEEF with ready.
REQ-034 Alias: write 0x1234 to addr 0x0105, then read addr 0x0005 -> rdata=0x1234.
REQ-035 Hold: keep MemRead=1 for 6 cycles after ready -> exactly one ready pulse, busy=1 until MemRead falls, then IDLE.
REQ-036 Illegal request: MemRead=MemWrite=1 at addr 0x0020 holding 0x00AA -> ready and err pulse together; a later read returns 0x00AA.
REQ-037 Reset abort: write 0x5555 to addr 0x0030 (previously 0x0001), pulse rst_n low mid-BUSY -> no ready, outputs 0; a later read returns 0x0001.
REQ-038 Latency sweep: LATENCY=1 and LATENCY=15 -> ready rises on edge E1 and edge E15 respectively after the sampling edge.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared defaults and state encoding for the memory responder slice.
package mem_pkg;
  localparam int DATA_W_D = 16;
  localparam int ADDR_W_D = 16;
  localparam int IDX_W_D  = 8;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_ILL} op_t;
endpackage

// File: rtl/mem_responder_if.sv
// Controller <-> memory responder handshake bundle.
interface mem_responder_if #(
  parameter int DATA_W = mem_pkg::DATA_W_D,
  parameter int ADDR_W = mem_pkg::ADDR_W_D
);
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (output MemRead, MemWrite, addr, wdata, input rdata, ready, err, busy);
  modport slave  (input MemRead, MemWrite, addr, wdata, output rdata, ready, err, busy);
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM; only the read register is reset, storage is not.
module mem_array #(
  parameter int DATA_W = mem_pkg::DATA_W_D,
  parameter int IDX_W  = mem_pkg::IDX_W_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] ram [2**IDX_W];

  always_ff @(posedge clk)
    if (we) ram[idx] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= ram[idx];
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: latches a request, counts down, pulses ready,
// then waits in HOLD for the controller to drop the request.
module mem_responder import mem_pkg::*; #(
  parameter int DATA_W  = DATA_W_D,
  parameter int ADDR_W  = ADDR_W_D,
  parameter int IDX_W   = IDX_W_D,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_lat
    $error("mem_responder: LATENCY must be 1..15");
  end

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  op_t               op_q;
  logic              req, fire;
  logic              unused_addr_hi;

  assign req            = bus.MemRead | bus.MemWrite;
  assign fire           = (state == BUSY) && (cnt == '0);
  assign unused_addr_hi = ^bus.addr[ADDR_W-1:IDX_W];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = BUSY;
      BUSY:    if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = HOLD;
      HOLD:    if (!req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request fields are captured once in IDLE; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_RD;
    end else if (state == IDLE && req) begin
      cnt     <= CNT_W'(LATENCY - 1);
      idx_q   <= bus.addr[IDX_W-1:0];
      wdata_q <= bus.wdata;
      op_q    <= (bus.MemRead && bus.MemWrite) ? OP_ILL :
                 bus.MemWrite ? OP_WR : OP_RD;
    end else if (state == BUSY && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end

  // Outputs decode registered state only, so there is no comb path from requests.
  always_comb begin
    bus.ready = (state == DONE);
    bus.err   = (state == DONE) && (op_q == OP_ILL);
    bus.busy  = (state != IDLE);
  end

  mem_array #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (fire && op_q == OP_WR),
    .re    (fire && op_q == OP_RD),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (bus.rdata)
  );
endmodule

// File: tb/tb_mem_responder.sv
// Randomized + directed bench for mem_responder at LATENCY 2, 1 and 15.
module tb_mem_responder;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          mr = 1'b0, mw = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  int            sel = 0;

  mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
  mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
  mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) b2 ();

  assign b0.MemRead = mr && sel == 0;  assign b0.MemWrite = mw && sel == 0;
  assign b1.MemRead = mr && sel == 1;  assign b1.MemWrite = mw && sel == 1;
  assign b2.MemRead = mr && sel == 2;  assign b2.MemWrite = mw && sel == 2;
  assign b0.addr = addr;  assign b1.addr = addr;  assign b2.addr = addr;
  assign b0.wdata = wdata; assign b1.wdata = wdata; assign b2.wdata = wdata;

  mem_responder #(.LATENCY(2))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mem_responder #(.LATENCY(1))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mem_responder #(.LATENCY(15)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  logic [DW-1:0] o_rdata;
  logic          o_ready, o_err, o_busy;
  always_comb begin
    o_rdata = b0.rdata; o_ready = b0.ready; o_err = b0.err; o_busy = b0.busy;
    case (sel)
      1: begin o_rdata = b1.rdata; o_ready = b1.ready; o_err = b1.err; o_busy = b1.busy; end
      2: begin o_rdata = b2.rdata; o_ready = b2.ready; o_err = b2.err; o_busy = b2.busy; end
      default: ;
    endcase
  end

  // Reference model: word store per instance plus the last completed read value.
  logic [DW-1:0] mem_m [3][256];
  logic [DW-1:0] rd_m  [3];
  int total = 0, bad = 0;

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 1 : 15;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One request held for h (>=1) cycles past ready, then dropped.
  task automatic xact(input int s, input bit r, input bit w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input int h);
    int lat;
    logic [7:0] idx;
    logic [DW-1:0] old_rd;
    bit ill;
    lat = lat_of(s);
    idx = a[7:0];
    ill = r && w;
    @(negedge clk);
    sel = s; mr = r; mw = w; addr = a; wdata = d;
    @(posedge clk); #1;
    chk("busy_e0", 32'(o_busy), 32'd1);
    chk("ready_e0", 32'(o_ready), 32'd0);
    old_rd = rd_m[s];
    if (r && !w) rd_m[s] = mem_m[s][idx];
    if (w && !r) mem_m[s][idx] = d;
    for (int k = 1; k <= lat; k++) begin
      if (k < lat) begin addr = 16'($urandom); wdata = 16'($urandom); end
      @(posedge clk); #1;
      chk($sformatf("ready_e%0d_l%0d", k, lat), 32'(o_ready), 32'(k == lat));
      if (k == lat) begin
        chk("err", 32'(o_err), 32'(ill));
        chk("rdata_done", 32'(o_rdata), 32'(rd_m[s]));
      end else begin
        chk("rdata_busy", 32'(o_rdata), 32'(old_rd));
      end
    end
    for (int i = 0; i < h; i++) begin
      @(posedge clk); #1;
      chk("hold_ready", 32'(o_ready), 32'd0);
      chk("hold_busy", 32'(o_busy), 32'd1);
    end
    @(negedge clk);
    mr = 1'b0; mw = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_rdata", 32'(o_rdata), 32'(rd_m[s]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("rst_rdata", 32'(o_rdata), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      rd_m[s] = '0;
    end
    @(negedge clk) rst_n = 1'b1;

    xact(0, 0, 1, 16'h0012, 16'hBEEF, 1);
    xact(0, 1, 0, 16'h0012, 16'h0000, 1);
    xact(0, 0, 1, 16'h0105, 16'h1234, 1);
    xact(0, 1, 0, 16'h0005, 16'h0000, 1);
    xact(0, 1, 0, 16'h0012, 16'h0000, 6);
    xact(0, 0, 1, 16'h0020, 16'h00AA, 1);
    xact(0, 1, 1, 16'h0020, 16'h1111, 2);
    xact(0, 1, 0, 16'h0020, 16'h0000, 1);

    // Abort a write with reset mid-access; old contents must survive.
    xact(0, 0, 1, 16'h0030, 16'h0001, 1);
    @(negedge clk);
    sel = 0; mw = 1'b1; addr = 16'h0030; wdata = 16'h5555;
    @(posedge clk); #1;
    chk("abort_busy", 32'(o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(o_ready), 32'd0);
    chk("abort_busy0", 32'(o_busy), 32'd0);
    chk("abort_err", 32'(o_err), 32'd0);
    chk("abort_rdata", 32'(o_rdata), 32'd0);
    for (int s = 0; s < 3; s++) rd_m[s] = '0;
    repeat (2) @(posedge clk);
    #1 chk("abort_noready", 32'(o_ready), 32'd0);
    @(negedge clk);
    mw = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", 32'(o_busy), 32'd0);
    xact(0, 1, 0, 16'h0030, 16'h0000, 1);

    xact(1, 0, 1, 16'h0040, 16'hC0DE, 1);
    xact(1, 1, 0, 16'h0040, 16'h0000, 1);
    xact(2, 0, 1, 16'h0041, 16'hFACE, 1);
    xact(2, 1, 0, 16'h0041, 16'h0000, 2);

    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 16; i++)
        xact(s, 0, 1, {8'($urandom), 8'(i)}, 16'($urandom), 1);
    for (int n = 0; n < 40; n++) begin
      int s, op;
      s  = $urandom_range(0, 2);
      op = $urandom_range(0, 4);
      xact(s, op < 2 || op == 4, op >= 2, {8'($urandom), 8'($urandom_range(0, 15))},
           16'($urandom), $urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
